// File: rtl/keccak_pkg.sv
// keccak_pkg
//   Shared types and constants for the Keccak permutation controller:
//   mode and step encodings, controller state enum, per-mode rate/suffix
//   constants and the step-order helper.
package keccak_pkg;

   localparam int unsigned MAX_ROUNDS       = 24;
   localparam int unsigned STEP_NUM         = 5;
   localparam int unsigned STATE_WIDTH      = 1600;
   localparam int unsigned MODE_SEL_WIDTH   = 2;
   localparam int unsigned RATE_WIDTH       = 11;
   localparam int unsigned CAPACITY_WIDTH   = 11;
   localparam int unsigned SUFFIX_WIDTH     = 4;
   localparam int unsigned SUFFIX_LEN_WIDTH = 3;
   localparam int unsigned ROUND_INDEX_SIZE = 5;

   typedef enum logic [MODE_SEL_WIDTH-1:0] {
      SHA3_256 = 2'd0,
      SHA3_512 = 2'd1,
      SHAKE128 = 2'd2,
      SHAKE256 = 2'd3
   } keccak_mode;

   typedef enum logic [2:0] {
      ZERO_STEP  = 3'd0,
      THETA_STEP = 3'd1,
      RHO_STEP   = 3'd2,
      PI_STEP    = 3'd3,
      CHI_STEP   = 3'd4,
      IOTA_STEP  = 3'd5
   } keccak_step;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'd0,
      CTRL_ZERO = 2'd1,
      CTRL_STEP = 2'd2,
      CTRL_DONE = 2'd3
   } ctrl_state_e;

   localparam logic [RATE_WIDTH-1:0] RATE_SHA3_256 = 11'd1088;
   localparam logic [RATE_WIDTH-1:0] RATE_SHA3_512 = 11'd576;
   localparam logic [RATE_WIDTH-1:0] RATE_SHAKE128 = 11'd1344;
   localparam logic [RATE_WIDTH-1:0] RATE_SHAKE256 = 11'd1088;

   localparam logic [SUFFIX_WIDTH-1:0]     SUFFIX_SHA3      = 4'h2;
   localparam logic [SUFFIX_WIDTH-1:0]     SUFFIX_SHAKE     = 4'hF;
   localparam logic [SUFFIX_LEN_WIDTH-1:0] SUFFIX_LEN_SHA3  = 3'd2;
   localparam logic [SUFFIX_LEN_WIDTH-1:0] SUFFIX_LEN_SHAKE = 3'd4;

   localparam logic [CAPACITY_WIDTH-1:0] CAP_SHA3_256 =
      CAPACITY_WIDTH'(STATE_WIDTH - 32'(RATE_SHA3_256));

   localparam logic [ROUND_INDEX_SIZE-1:0] LAST_ROUND =
      ROUND_INDEX_SIZE'(MAX_ROUNDS - 1);

   // Step that follows s within a round; IOTA wraps to THETA (round
   // advance is handled by the caller).
   function automatic keccak_step next_step(input keccak_step s);
      keccak_step n;
      n = THETA_STEP;
      case (s)
         THETA_STEP: n = RHO_STEP;
         RHO_STEP:   n = PI_STEP;
         PI_STEP:    n = CHI_STEP;
         CHI_STEP:   n = IOTA_STEP;
         default:    n = THETA_STEP;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/keccak_mode_decode.sv
// keccak_mode_decode
//   Combinational decode of a Keccak mode into sponge parameters.
//   Ports:
//     i_mode        mode select (keccak_mode encoding)
//     o_rate        rate in bits
//     o_capacity    1600 - rate
//     o_suffix      domain-separation bits, LSB first
//     o_suffix_len  number of valid suffix bits
module keccak_mode_decode
   import keccak_pkg::*;
(
   input  logic [MODE_SEL_WIDTH-1:0]   i_mode,
   output logic [RATE_WIDTH-1:0]       o_rate,
   output logic [CAPACITY_WIDTH-1:0]   o_capacity,
   output logic [SUFFIX_WIDTH-1:0]     o_suffix,
   output logic [SUFFIX_LEN_WIDTH-1:0] o_suffix_len
);

   logic [RATE_WIDTH-1:0] w_rate;

   always_comb begin
      w_rate       = RATE_SHA3_256;
      o_suffix     = SUFFIX_SHA3;
      o_suffix_len = SUFFIX_LEN_SHA3;
      case (keccak_mode'(i_mode))
         SHA3_256: begin
            w_rate       = RATE_SHA3_256;
            o_suffix     = SUFFIX_SHA3;
            o_suffix_len = SUFFIX_LEN_SHA3;
         end
         SHA3_512: begin
            w_rate       = RATE_SHA3_512;
            o_suffix     = SUFFIX_SHA3;
            o_suffix_len = SUFFIX_LEN_SHA3;
         end
         SHAKE128: begin
            w_rate       = RATE_SHAKE128;
            o_suffix     = SUFFIX_SHAKE;
            o_suffix_len = SUFFIX_LEN_SHAKE;
         end
         SHAKE256: begin
            w_rate       = RATE_SHAKE256;
            o_suffix     = SUFFIX_SHAKE;
            o_suffix_len = SUFFIX_LEN_SHAKE;
         end
         default: begin
            w_rate       = RATE_SHA3_256;
            o_suffix     = SUFFIX_SHA3;
            o_suffix_len = SUFFIX_LEN_SHA3;
         end
      endcase
   end

   assign o_rate     = w_rate;
   assign o_capacity = CAPACITY_WIDTH'(STATE_WIDTH - 32'(w_rate));

endmodule

// File: rtl/keccak_perm_ctrl.sv
// keccak_perm_ctrl
//   Sequencer for the Keccak step datapath. Either clears the state array
//   (one ZERO cycle, latching the mode configuration) or runs a full
//   Keccak-f[1600] permutation: 24 rounds of THETA/RHO/PI/CHI/IOTA, one
//   step per cycle. All outputs are registered.
//   Optional build macro: KECCAK_CTRL_ABORT_EN adds abort_i, which returns
//   a running operation to IDLE without a done pulse.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start_i         request, accepted only while start_ready_o=1
//     clear_i         with start_i: 1=clear + latch mode, 0=permute
//     mode_i          mode, sampled only on an accepted clear
//     abort_i         (KECCAK_CTRL_ABORT_EN only) abort running operation
//     start_ready_o   high in IDLE
//     busy_o          high in ZERO/STEP
//     done_o          one-cycle pulse at end of operation
//     step_sel_o      keccak_step driven to the datapath
//     round_idx_o     current round for the iota constant lookup
//     state_we_o      state-array write enable
//     rate_o, capacity_o, suffix_o, suffix_len_o  latched mode config
module keccak_perm_ctrl
   import keccak_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_i,
   input  logic                        clear_i,
   input  logic [MODE_SEL_WIDTH-1:0]   mode_i,
`ifdef KECCAK_CTRL_ABORT_EN
   input  logic                        abort_i,
`endif
   output logic                        start_ready_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [2:0]                  step_sel_o,
   output logic [ROUND_INDEX_SIZE-1:0] round_idx_o,
   output logic                        state_we_o,
   output logic [RATE_WIDTH-1:0]       rate_o,
   output logic [CAPACITY_WIDTH-1:0]   capacity_o,
   output logic [SUFFIX_WIDTH-1:0]     suffix_o,
   output logic [SUFFIX_LEN_WIDTH-1:0] suffix_len_o
);

   ctrl_state_e                  r_state;
   keccak_step                   r_step;
   logic [ROUND_INDEX_SIZE-1:0]  r_round;
   logic                         r_ready;
   logic                         r_busy;
   logic                         r_done;
   logic                         r_we;
   logic [RATE_WIDTH-1:0]        r_rate;
   logic [CAPACITY_WIDTH-1:0]    r_cap;
   logic [SUFFIX_WIDTH-1:0]      r_suffix;
   logic [SUFFIX_LEN_WIDTH-1:0]  r_suffix_len;

   logic                         w_abort;
   logic [RATE_WIDTH-1:0]        w_rate;
   logic [CAPACITY_WIDTH-1:0]    w_cap;
   logic [SUFFIX_WIDTH-1:0]      w_suffix;
   logic [SUFFIX_LEN_WIDTH-1:0]  w_suffix_len;

`ifdef KECCAK_CTRL_ABORT_EN
   assign w_abort = abort_i;
`else
   assign w_abort = 1'b0;
`endif

   keccak_mode_decode u_mode_decode (
      .i_mode       (mode_i),
      .o_rate       (w_rate),
      .o_capacity   (w_cap),
      .o_suffix     (w_suffix),
      .o_suffix_len (w_suffix_len)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= CTRL_IDLE;
         r_step       <= ZERO_STEP;
         r_round      <= '0;
         r_ready      <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_we         <= 1'b0;
         r_rate       <= RATE_SHA3_256;
         r_cap        <= CAP_SHA3_256;
         r_suffix     <= SUFFIX_SHA3;
         r_suffix_len <= SUFFIX_LEN_SHA3;
      end else begin
         case (r_state)
            CTRL_IDLE: begin
               r_done  <= 1'b0;
               r_step  <= ZERO_STEP;
               r_round <= '0;
               r_we    <= 1'b0;
               if (start_i) begin
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_we    <= 1'b1;
                  if (clear_i) begin
                     r_state      <= CTRL_ZERO;
                     r_rate       <= w_rate;
                     r_cap        <= w_cap;
                     r_suffix     <= w_suffix;
                     r_suffix_len <= w_suffix_len;
                  end else begin
                     r_state <= CTRL_STEP;
                     r_step  <= THETA_STEP;
                  end
               end
            end

            CTRL_ZERO: begin
               r_we   <= 1'b0;
               r_busy <= 1'b0;
               r_step <= ZERO_STEP;
               if (w_abort) begin
                  r_state <= CTRL_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= CTRL_DONE;
                  r_done  <= 1'b1;
               end
            end

            CTRL_STEP: begin
               // Abort outranks the final IOTA: the write of the current
               // cycle is already committed, only the done pulse is lost.
               if (w_abort) begin
                  r_state <= CTRL_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_we    <= 1'b0;
                  r_step  <= ZERO_STEP;
                  r_round <= '0;
               end else if (r_step == IOTA_STEP) begin
                  if (r_round == LAST_ROUND) begin
                     r_state <= CTRL_DONE;
                     r_busy  <= 1'b0;
                     r_we    <= 1'b0;
                     r_done  <= 1'b1;
                     r_step  <= ZERO_STEP;
                     r_round <= '0;
                  end else begin
                     r_round <= r_round + 1'b1;
                     r_step  <= THETA_STEP;
                  end
               end else begin
                  r_step <= next_step(r_step);
               end
            end

            CTRL_DONE: begin
               r_state <= CTRL_IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
               r_step  <= ZERO_STEP;
               r_round <= '0;
            end

            default: begin
               r_state <= CTRL_IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
               r_step  <= ZERO_STEP;
               r_round <= '0;
            end
         endcase
      end
   end

   assign start_ready_o = r_ready;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign step_sel_o    = r_step;
   assign round_idx_o   = r_round;
   assign state_we_o    = r_we;
   assign rate_o        = r_rate;
   assign capacity_o    = r_cap;
   assign suffix_o      = r_suffix;
   assign suffix_len_o  = r_suffix_len;

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// tb_keccak_perm_ctrl
//   Bench for keccak_perm_ctrl. The reference model tracks only the current
//   operation (none/clear/permute) and the cycle count since it was
//   accepted; expected outputs follow from that count with plain arithmetic.
//   Honours KECCAK_CTRL_ABORT_EN when defined.
module tb_keccak_perm_ctrl;
   import keccak_pkg::*;

   localparam int OP_NONE = 0;
   localparam int OP_CLR  = 1;
   localparam int OP_PRM  = 2;
   localparam int PERM_CYCLES = 24 * 5;

   logic                        clk;
   logic                        rst_n;
   logic                        start_i;
   logic                        clear_i;
   logic [MODE_SEL_WIDTH-1:0]   mode_i;
   logic                        abort_i;
   logic                        start_ready_o;
   logic                        busy_o;
   logic                        done_o;
   logic [2:0]                  step_sel_o;
   logic [ROUND_INDEX_SIZE-1:0] round_idx_o;
   logic                        state_we_o;
   logic [RATE_WIDTH-1:0]       rate_o;
   logic [CAPACITY_WIDTH-1:0]   capacity_o;
   logic [SUFFIX_WIDTH-1:0]     suffix_o;
   logic [SUFFIX_LEN_WIDTH-1:0] suffix_len_o;

   int n_checks;
   int n_fail;
   int n_done;

   // model state
   int          m_op;
   int          m_t;
   int unsigned m_rate, m_cap, m_suf, m_len;
   bit          abort_en;

   keccak_step step_order [5];

   keccak_perm_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .clear_i       (clear_i),
      .mode_i        (mode_i),
`ifdef KECCAK_CTRL_ABORT_EN
      .abort_i       (abort_i),
`endif
      .start_ready_o (start_ready_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .step_sel_o    (step_sel_o),
      .round_idx_o   (round_idx_o),
      .state_we_o    (state_we_o),
      .rate_o        (rate_o),
      .capacity_o    (capacity_o),
      .suffix_o      (suffix_o),
      .suffix_len_o  (suffix_len_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Sponge parameters straight from the mode table.
   task automatic model_mode(input int unsigned md);
      case (md)
         0:       begin m_rate = 1088; m_suf = 4'h2; m_len = 2; end
         1:       begin m_rate = 576;  m_suf = 4'h2; m_len = 2; end
         2:       begin m_rate = 1344; m_suf = 4'hF; m_len = 4; end
         default: begin m_rate = 1088; m_suf = 4'hF; m_len = 4; end
      endcase
      m_cap = 1600 - m_rate;
   endtask

   task automatic model_reset();
      m_op = OP_NONE;
      m_t  = 0;
      model_mode(0);
   endtask

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_ready"}, start_ready_o, 1);
      check_eq({pfx, "_busy"},  busy_o, 0);
      check_eq({pfx, "_done"},  done_o, 0);
      check_eq({pfx, "_we"},    state_we_o, 0);
      check_eq({pfx, "_step"},  step_sel_o, ZERO_STEP);
      check_eq({pfx, "_round"}, round_idx_o, 0);
      check_eq({pfx, "_rate"},  rate_o, 1088);
      check_eq({pfx, "_cap"},   capacity_o, 512);
      check_eq({pfx, "_suf"},   suffix_o, 4'h2);
      check_eq({pfx, "_len"},   suffix_len_o, 2);
   endtask

   // One clock: check current outputs against the model, drive the next
   // inputs, then advance the model across the coming rising edge.
   task automatic step_cycle(input bit st, input bit cl, input int unsigned md, input bit ab);
      int unsigned e_ready, e_busy, e_done, e_we, e_step, e_round;
      int k;
      int end_t;
      @(negedge clk);
      e_ready = 1; e_busy = 0; e_done = 0; e_we = 0; e_step = ZERO_STEP; e_round = 0;
      if (m_op == OP_CLR) begin
         e_ready = 0;
         if (m_t == 1) begin e_busy = 1; e_we = 1; end
         else e_done = 1;
      end else if (m_op == OP_PRM) begin
         e_ready = 0;
         if (m_t <= PERM_CYCLES) begin
            k = m_t - 1;
            e_busy = 1; e_we = 1;
            e_step = step_order[k % 5];
            e_round = k / 5;
         end else e_done = 1;
      end
      if (done_o) n_done++;
      check_eq("ready", start_ready_o, e_ready);
      check_eq("busy",  busy_o, e_busy);
      check_eq("done",  done_o, e_done);
      check_eq("we",    state_we_o, e_we);
      check_eq("step",  step_sel_o, e_step);
      check_eq("round", round_idx_o, e_round);
      check_eq("rate",  rate_o, m_rate);
      check_eq("cap",   capacity_o, m_cap);
      check_eq("suf",   suffix_o, m_suf);
      check_eq("len",   suffix_len_o, m_len);

      start_i = st;
      clear_i = cl;
      mode_i  = md[MODE_SEL_WIDTH-1:0];
      abort_i = ab;

      if (m_op == OP_NONE) begin
         if (st) begin
            m_op = cl ? OP_CLR : OP_PRM;
            m_t  = 1;
            if (cl) model_mode(md);
         end
      end else begin
         end_t = (m_op == OP_CLR) ? 2 : PERM_CYCLES + 1;
         if (abort_en && ab && m_t < end_t) begin
            m_op = OP_NONE; m_t = 0;
         end else if (m_t == end_t) begin
            m_op = OP_NONE; m_t = 0;
         end else begin
            m_t++;
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; n_done = 0;
`ifdef KECCAK_CTRL_ABORT_EN
      abort_en = 1'b1;
`else
      abort_en = 1'b0;
`endif
      step_order[0] = THETA_STEP; step_order[1] = RHO_STEP; step_order[2] = PI_STEP;
      step_order[3] = CHI_STEP;   step_order[4] = IOTA_STEP;
      model_reset();
      rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; mode_i = '0; abort_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_values("rst_held");
      @(negedge clk);
      rst_n = 1'b1;

      // reset release, no stimulus
      repeat (3) step_cycle(0, 0, 0, 0);

      // clear with SHAKE128
      step_cycle(1, 1, 2, 0);
      repeat (4) step_cycle(0, 0, 0, 0);

      // permute with start pulsed every cycle; exactly one done expected
      n_done = 0;
      step_cycle(1, 0, 0, 0);
      repeat (PERM_CYCLES + 1) step_cycle(1, $urandom_range(0, 1), $urandom_range(0, 3), 0);
      step_cycle(0, 0, 0, 0);
      check_eq("perm_done_count", n_done, 1);
      repeat (2) step_cycle(0, 0, 0, 0);

      // async reset at cycle 60 of a permute
      n_done = 0;
      step_cycle(1, 0, 0, 0);
      while (m_t < 60) step_cycle(0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_values("rst_mid");
      model_reset();
      start_i = 1'b0; clear_i = 1'b0; abort_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (130) step_cycle(0, 0, 0, 0);
      check_eq("rst_no_done", n_done, 0);

`ifdef KECCAK_CTRL_ABORT_EN
      // abort at cycle 30, then a full permute
      n_done = 0;
      step_cycle(1, 1, 3, 0);
      repeat (3) step_cycle(0, 0, 0, 0);
      step_cycle(1, 0, 0, 0);
      while (m_t < 30) step_cycle(0, 0, 0, 0);
      step_cycle(0, 0, 0, 1);
      step_cycle(0, 0, 0, 0);
      check_eq("abort_ready", start_ready_o, 1);
      check_eq("abort_no_done", n_done, 0);
      step_cycle(1, 0, 0, 0);
      repeat (PERM_CYCLES + 3) step_cycle(0, 0, 0, 0);
      check_eq("post_abort_done", n_done, 1);
      // abort coinciding with the final IOTA
      n_done = 0;
      step_cycle(1, 0, 0, 0);
      while (m_t < PERM_CYCLES) step_cycle(0, 0, 0, 0);
      step_cycle(0, 0, 0, 1);
      repeat (3) step_cycle(0, 0, 0, 0);
      check_eq("abort_iota_no_done", n_done, 0);
`endif

      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         step_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 3), ($urandom_range(0, 63) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Hard time bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
